param_loader: RTL and testbench

- Upstream feeder for the two-layer network top.
- Accepts a stream of signed fixed-point parameter words over a valid/ready input and drives them onto the network's shared 2n-bit parameter bus.
- Pulses exactly one node write-enable per accepted word, so each node's shift register captures its fan-in weights followed by its bias.
- Sequences all nodes of hidden layer 1, then the output layer, and reports completion.

---
 rtl/param_loader.sv | 141 ++++++++++++++
 tb/tb_param_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/param_loader.sv
// param_loader: streams signed fixed-point parameter words from a valid/ready
// input onto the network's shared 2N-bit parameter bus. Each accepted word is
// presented on the bus for one cycle together with a one-hot write-enable for
// the node that owns it. Layer-1 nodes are loaded first, then the output layer.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// LOAD  | accepting words; s_ready high; each transfer shifts one node next cycle
// FLUSH | final word on bus with its we bit; no further words accepted
// DONE  | one-cycle completion pulse, bus released
module param_loader #(
    parameter int N   = 16,
    parameter int SX  = 4,
    parameter int SL1 = 4,
    parameter int SL  = 2,
    parameter int ND  = SL1 + SL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*N-1:0]  s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [2*N-1:0]  bus,
    output logic            bus_oe,
    output logic [ND-1:0]   we,
    output logic            busy,
    output logic            done
);

    localparam int MAXF   = (SX > SL1) ? SX : SL1;
    localparam int NODE_W = (ND > 1) ? $clog2(ND) : 1;
    localparam int WORD_W = $clog2(MAXF + 1);

    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(ND - 1);
    localparam logic [NODE_W-1:0] L1_NODES  = NODE_W'(SL1);
    localparam logic [WORD_W-1:0] FAN_L1    = WORD_W'(SX);
    localparam logic [WORD_W-1:0] FAN_OUT   = WORD_W'(SL1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [NODE_W-1:0]   node_cnt, node_nxt;
    logic [WORD_W-1:0]   word_cnt, word_nxt;
    logic [2*N-1:0]      bus_nxt;
    logic [ND-1:0]       we_nxt;
    logic                bus_oe_nxt;
    logic [WORD_W-1:0]   fanin;
    logic [ND-1:0]       node_sel;
    logic                xfer;

    // Handshake and status decode straight from the state register.
    always_comb begin
        s_ready = (state == LOAD);
        busy    = (state == LOAD) || (state == FLUSH);
        done    = (state == DONE);
    end

    // Current node's fan-in and its one-hot enable (node 0 maps to the MSB).
    always_comb begin
        fanin    = (node_cnt < L1_NODES) ? FAN_L1 : FAN_OUT;
        node_sel = '0;
        for (int i = 0; i < ND; i++) begin
            node_sel[i] = (NODE_W'(ND - 1 - i) == node_cnt);
        end
        xfer = s_valid && (state == LOAD);
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_nxt  = state;
        node_nxt   = node_cnt;
        word_nxt   = word_cnt;
        bus_nxt    = bus;
        we_nxt     = '0;
        bus_oe_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    node_nxt  = '0;
                    word_nxt  = '0;
                end
            end
            LOAD: begin
                // The bus stays driven through stalls so the network sees a stable value.
                bus_oe_nxt = 1'b1;
                if (xfer) begin
                    bus_nxt = s_data;
                    we_nxt  = node_sel;
                    if (word_cnt == fanin) begin
                        word_nxt = '0;
                        if (node_cnt == LAST_NODE) begin
                            // Counter parks at its terminal value; FLUSH lets the last word land.
                            state_nxt = FLUSH;
                        end else begin
                            node_nxt = node_cnt + 1'b1;
                        end
                    end else begin
                        word_nxt = word_cnt + 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and bus-side outputs; reset aborts any sequence at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            node_cnt <= '0;
            word_cnt <= '0;
            bus      <= '0;
            we       <= '0;
            bus_oe   <= 1'b0;
        end else begin
            state    <= state_nxt;
            node_cnt <= node_nxt;
            word_cnt <= word_nxt;
            bus      <= bus_nxt;
            we       <= we_nxt;
            bus_oe   <= bus_oe_nxt;
        end
    end

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader with SX=2, SL1=3, SL=2 (17 words per load).
module tb_param_loader;

    localparam int N     = 16;
    localparam int SX    = 2;
    localparam int SL1   = 3;
    localparam int SL    = 2;
    localparam int ND    = 5;
    localparam int NWORD = 17;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2*N-1:0]  s_data;
    logic            s_valid;
    logic            s_ready;
    logic [2*N-1:0]  bus;
    logic            bus_oe;
    logic [ND-1:0]   we;
    logic            busy;
    logic            done;

    int checks;
    int failures;

    typedef struct {
        logic [2*N-1:0] data;
        logic [ND-1:0]  we;
    } vec_t;

    vec_t           vecs[NWORD];
    logic [2*N-1:0] xdata[NWORD];

    param_loader #(.N(N), .SX(SX), .SL1(SL1), .SL(SL), .ND(ND)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .bus     (bus),
        .bus_oe  (bus_oe),
        .we      (we),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_bus"},     64'(bus),     64'd0);
        chk({tag, "_bus_oe"},  64'(bus_oe),  64'd0);
        chk({tag, "_we"},      64'(we),      64'd0);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_busy"},    64'(busy),    64'd0);
        chk({tag, "_done"},    64'(done),    64'd0);
    endtask

    // Called at a negedge with the DUT in IDLE. Drives one load sequence,
    // checking every cycle; returns at a negedge with the DUT back in IDLE.
    task automatic run_load(input bit use_x, input bit stall, input int abort_after,
                            input bit mid_start, input bit start_in_done);
        int             idx;
        int             cyc;
        bit             acc;
        logic [2*N-1:0] last_bus;
        logic [2*N-1:0] w;
        idx      = 0;
        cyc      = 0;
        acc      = 1'b0;
        last_bus = '0;
        start    = 1'b1;
        s_valid  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        while (idx < NWORD) begin
            if (cyc > 0) begin
                chk("bus_oe_load", 64'(bus_oe), 64'd1);
                if (acc) begin
                    w = use_x ? xdata[idx-1] : vecs[idx-1].data;
                    chk("bus_word", 64'(bus), 64'(w));
                    chk("we_word",  64'(we),  64'(vecs[idx-1].we));
                    last_bus = w;
                end else begin
                    chk("we_gap",  64'(we),  64'd0);
                    chk("bus_gap", 64'(bus), 64'(last_bus));
                end
            end
            chk("s_ready_load", 64'(s_ready), 64'd1);
            chk("busy_load",    64'(busy),    64'd1);
            chk("done_load",    64'(done),    64'd0);
            if (abort_after > 0 && acc && idx == abort_after) begin
                rst = 1'b0;
                #1;
                chk_quiet("abort");
                s_valid = 1'b0;
                start   = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                chk_quiet("after_abort");
                return;
            end
            acc     = stall ? (cyc % 2 == 0) : 1'b1;
            s_valid = acc;
            s_data  = acc ? (use_x ? xdata[idx] : vecs[idx].data) : 32'hDEAD_BEEF;
            start   = mid_start && (idx == 5);
            if (acc) idx++;
            cyc++;
            @(negedge clk);
        end
        // FLUSH: last word on bus, no more words taken even with valid high.
        w = use_x ? xdata[NWORD-1] : vecs[NWORD-1].data;
        chk("flush_bus",     64'(bus),     64'(w));
        chk("flush_we",      64'(we),      64'(vecs[NWORD-1].we));
        chk("flush_bus_oe",  64'(bus_oe),  64'd1);
        chk("flush_s_ready", 64'(s_ready), 64'd0);
        chk("flush_busy",    64'(busy),    64'd1);
        chk("flush_done",    64'(done),    64'd0);
        s_valid = 1'b1;
        s_data  = 32'h5A5A_5A5A;
        start   = 1'b0;
        @(negedge clk);
        // DONE
        chk("done_pulse",   64'(done),    64'd1);
        chk("done_busy",    64'(busy),    64'd0);
        chk("done_we",      64'(we),      64'd0);
        chk("done_bus_oe",  64'(bus_oe),  64'd0);
        chk("done_s_ready", 64'(s_ready), 64'd0);
        chk("done_bus",     64'(bus),     64'(w));
        start   = start_in_done;
        s_valid = 1'b0;
        @(negedge clk);
        // IDLE
        chk("idle_done", 64'(done),    64'd0);
        chk("idle_busy", 64'(busy),    64'd0);
        chk("idle_we",   64'(we),      64'd0);
        chk("idle_rdy",  64'(s_ready), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < NWORD; i++) begin
            vecs[i].data = 32'(i + 1);
            vecs[i].we   = (i < 3)  ? 5'b10000 :
                           (i < 6)  ? 5'b01000 :
                           (i < 9)  ? 5'b00100 :
                           (i < 13) ? 5'b00010 : 5'b00001;
            xdata[i]     = 32'(i + 1);
        end
        xdata[0] = 32'h8000_0000;
        xdata[1] = 32'hFFFF_FFFF;
        xdata[2] = 32'h7FFF_FFFF;
        xdata[3] = 32'h0000_8000;
        xdata[4] = 32'h0000_FFFF;
        xdata[5] = 32'h0000_7FFF;
        xdata[9] = 32'hFFFF_8000;

        // Reset held with start and valid asserted.
        rst     = 1'b0;
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset");
        start = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet("idle_wait");
        end
        s_valid = 1'b0;

        run_load(1'b0, 1'b0, 0, 1'b0, 1'b0);   // plain full load
        run_load(1'b0, 1'b1, 0, 1'b0, 1'b0);   // 1010 valid stalls
        run_load(1'b1, 1'b0, 0, 1'b0, 1'b0);   // extreme values
        run_load(1'b0, 1'b0, 7, 1'b0, 1'b0);   // abort after word 7
        run_load(1'b0, 1'b0, 0, 1'b1, 1'b1);   // start mid-load and in DONE
        run_load(1'b0, 1'b1, 0, 1'b0, 1'b0);   // restart from next IDLE

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
